// File: rtl/com_arb_fsm.sv
// Round-robin write-side arbiter for the shared wclk-domain FIFO.
// Grants one channel per burst, honours wfull and caps burst length.
module com_arb_fsm #(
   parameter int NCH       = 4,
   parameter int SELW      = 2,
   parameter int MAX_BURST = 16,
   parameter int CNT_W     = 5,
   parameter int REST      = 2
) (
   input  logic             wclk,
   input  logic             wrst_n,
   input  logic [NCH-1:0]   req,
   input  logic             wfull,
   output logic [NCH-1:0]   grant,
   output logic             w_en,
   output logic [SELW-1:0]  sel,
   output logic             busy,
   output logic [CNT_W-1:0] burst_cnt
);

   localparam int RW = (REST > 1) ? $clog2(REST) : 1;
   localparam logic [RW-1:0] REST_LAST =
      RW'((REST > 0) ? REST - 1 : 0);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'(MAX_BURST - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_DATA,
      S_REST
   } state_t;

   state_t           state_q, state_d;
   logic [SELW-1:0]  rr_q, rr_d;
   logic [SELW-1:0]  sel_q, sel_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [RW-1:0]    rest_q, rest_d;

   logic             found;
   logic [SELW-1:0]  win;
   logic             req_sel;
   logic [NCH-1:0]   grant_c;
   logic             wen_c;

   // Scan from rr_q upward, then wrap to the channels below it.
   always_comb begin
      found = 1'b0;
      win   = '0;
      for (int i = 0; i < NCH; i++) begin
         if (!found && i >= int'(rr_q) && req[i]) begin
            found = 1'b1;
            win   = SELW'(i);
         end
      end
      for (int i = 0; i < NCH; i++) begin
         if (!found && i < int'(rr_q) && req[i]) begin
            found = 1'b1;
            win   = SELW'(i);
         end
      end
   end

   always_comb begin
      req_sel = 1'b0;
      for (int i = 0; i < NCH; i++) begin
         if (SELW'(i) == sel_q) req_sel = req[i];
      end
   end

   always_comb begin
      state_d = state_q;
      rr_d    = rr_q;
      sel_d   = sel_q;
      cnt_d   = cnt_q;
      rest_d  = rest_q;
      grant_c = '0;
      wen_c   = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (found) begin
               for (int i = 0; i < NCH; i++) begin
                  grant_c[i] = (SELW'(i) == win);
               end
               sel_d   = win;
               cnt_d   = '0;
               state_d = S_DATA;
            end
         end
         S_DATA: begin
            wen_c = !wfull;
            for (int i = 0; i < NCH; i++) begin
               grant_c[i] = (SELW'(i) == sel_q) && req_sel
                            && (cnt_q != CNT_LAST);
            end
            // Exit only on a real write so a trailing word survives wfull.
            if (wen_c) begin
               cnt_d = cnt_q + 1'b1;
               if (!req_sel || cnt_q == CNT_LAST) begin
                  rr_d    = (int'(sel_q) == NCH - 1) ? '0
                                                     : sel_q + 1'b1;
                  rest_d  = '0;
                  state_d = (REST > 0) ? S_REST : S_IDLE;
               end
            end
         end
         S_REST: begin
            rest_d = rest_q + 1'b1;
            if (rest_q == REST_LAST) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge wclk or negedge wrst_n) begin
      if (!wrst_n) begin
         state_q <= S_IDLE;
         rr_q    <= '0;
         sel_q   <= '0;
         cnt_q   <= '0;
         rest_q  <= '0;
      end else begin
         state_q <= state_d;
         rr_q    <= rr_d;
         sel_q   <= sel_d;
         cnt_q   <= cnt_d;
         rest_q  <= rest_d;
      end
   end

   // IDLE grant is combinational, so mask it while reset is held.
   assign grant     = wrst_n ? grant_c : '0;
   assign w_en      = wrst_n & wen_c;
   assign busy      = (state_q != S_IDLE);
   assign sel       = sel_q;
   assign burst_cnt = cnt_q;

endmodule

// File: tb/tb_com_arb_fsm.sv
// Directed scoreboard bench for com_arb_fsm across three
// parameter sets: default, MAX_BURST=4, and NCH=2 with REST=0.
module tb_com_arb_fsm;

   typedef struct packed {
      logic [3:0] g;
      logic       w;
      logic       b;
      logic [1:0] s;
      logic [4:0] c;
   } exp_t;

   logic       wclk;
   logic       wrst_n;
   logic       wfull;
   logic [3:0] req_a, req_b;
   logic [1:0] req_c;

   logic [3:0] grant_a, grant_b;
   logic [1:0] grant_c;
   logic       w_en_a, w_en_b, w_en_c;
   logic [1:0] sel_a, sel_b;
   logic       sel_c;
   logic       busy_a, busy_b, busy_c;
   logic [4:0] cnt_a, cnt_b, cnt_c;

   exp_t sbq[$];
   int   cur;
   int   step;
   int   n_total;
   int   n_pass;
   int   n_fail;

   com_arb_fsm u_a (
      .wclk(wclk), .wrst_n(wrst_n), .req(req_a),
      .wfull(wfull), .grant(grant_a), .w_en(w_en_a),
      .sel(sel_a), .busy(busy_a), .burst_cnt(cnt_a)
   );

   com_arb_fsm #(.MAX_BURST(4)) u_b (
      .wclk(wclk), .wrst_n(wrst_n), .req(req_b),
      .wfull(wfull), .grant(grant_b), .w_en(w_en_b),
      .sel(sel_b), .busy(busy_b), .burst_cnt(cnt_b)
   );

   com_arb_fsm #(.NCH(2), .SELW(1), .REST(0)) u_c (
      .wclk(wclk), .wrst_n(wrst_n), .req(req_c),
      .wfull(wfull), .grant(grant_c), .w_en(w_en_c),
      .sel(sel_c), .busy(busy_c), .burst_cnt(cnt_c)
   );

   initial wclk = 1'b0;
   always #5 wclk = ~wclk;

   function automatic exp_t obs();
      if (cur == 0) return {grant_a, w_en_a, busy_a, sel_a, cnt_a};
      if (cur == 1) return {grant_b, w_en_b, busy_b, sel_b, cnt_b};
      return {2'b00, grant_c, w_en_c, busy_c, 1'b0, sel_c, cnt_c};
   endfunction

   task automatic cmp(input string nm, input logic [4:0] act,
                      input logic [4:0] want);
      n_total++;
      assert (act === want) n_pass++;
      else begin
         n_fail++;
         $error("FAIL dut%0d step%0d %s got %b want %b",
                cur, step, nm, act, want);
      end
   endtask

   task automatic check_pop();
      exp_t e;
      exp_t o;
      step++;
      if (sbq.size() == 0) begin
         n_total++;
         n_fail++;
         $error("FAIL step%0d scoreboard empty got 0 want 1", step);
      end else begin
         e = sbq.pop_front();
         o = obs();
         cmp("grant", {1'b0, o.g}, {1'b0, e.g});
         cmp("w_en", {4'b0, o.w}, {4'b0, e.w});
         cmp("busy", {4'b0, o.b}, {4'b0, e.b});
         cmp("sel", {3'b0, o.s}, {3'b0, e.s});
         cmp("burst_cnt", o.c, e.c);
      end
   endtask

   task automatic drive(input logic [3:0] r);
      if (cur == 0) req_a = r;
      else if (cur == 1) req_b = r;
      else req_c = r[1:0];
   endtask

   task automatic expect_now(input logic [3:0] g, input logic w,
                             input logic b, input logic [1:0] s,
                             input logic [4:0] c);
      sbq.push_back({g, w, b, s, c});
      check_pop();
   endtask

   task automatic cyc(input logic [3:0] r, input logic f,
                      input logic [3:0] g, input logic w,
                      input logic b, input logic [1:0] s,
                      input logic [4:0] c);
      drive(r);
      wfull = f;
      sbq.push_back({g, w, b, s, c});
      @(negedge wclk);
      check_pop();
      @(posedge wclk);
      #1;
   endtask

   initial begin
      logic [3:0] oh;
      logic [1:0] ps;
      logic [4:0] pc;
      n_total = 0; n_pass = 0; n_fail = 0; step = 0;
      wrst_n = 1'b0; wfull = 1'b0;
      req_a = 4'b0001; req_b = 4'b0010; req_c = 2'b11;
      #2;
      cur = 0; expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      cur = 1; expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      cur = 2; expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      req_b = '0; req_c = '0;
      cur = 0;
      @(posedge wclk); #1;
      wrst_n = 1'b1;

      // single channel with trailing write
      cyc(4'b0001, 0, 4'b0001, 0, 0, 2'd0, 5'd0);
      cyc(4'b0001, 0, 4'b0001, 1, 1, 2'd0, 5'd0);
      cyc(4'b0001, 0, 4'b0001, 1, 1, 2'd0, 5'd1);
      cyc(4'b0000, 0, 4'b0000, 1, 1, 2'd0, 5'd2);
      cyc(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 5'd3);
      cyc(4'b0000, 0, 4'b0000, 0, 1, 2'd0, 5'd3);
      cyc(4'b0000, 0, 4'b0000, 0, 0, 2'd0, 5'd3);

      // reset pulse in IDLE with all requests high
      wrst_n = 1'b0;
      req_a = 4'b1111;
      #1;
      expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      @(posedge wclk); #1;
      wrst_n = 1'b1;

      // contention: 0,1,2,3,0 with full 16-write bursts
      ps = 2'd0; pc = 5'd0;
      for (int k = 0; k < 5; k++) begin
         oh = 4'(1 << (k % 4));
         cyc(4'hF, 0, oh, 0, 0, ps, pc);
         for (int i = 0; i < 16; i++) begin
            cyc(4'hF, 0, (i != 15) ? oh : 4'h0, 1, 1,
                2'(k % 4), 5'(i));
         end
         cyc(4'hF, 0, 4'h0, 0, 1, 2'(k % 4), 5'd16);
         cyc(4'hF, 0, 4'h0, 0, 1, 2'(k % 4), 5'd16);
         ps = 2'(k % 4);
         pc = 5'd16;
      end
      cyc(4'h0, 0, 4'h0, 0, 0, 2'd0, 5'd16);

      // backpressure on channel 2, req drops while full
      cyc(4'b0100, 0, 4'b0100, 0, 0, 2'd0, 5'd16);
      cyc(4'b0100, 0, 4'b0100, 1, 1, 2'd2, 5'd0);
      cyc(4'b0100, 0, 4'b0100, 1, 1, 2'd2, 5'd1);
      cyc(4'b0100, 0, 4'b0100, 1, 1, 2'd2, 5'd2);
      cyc(4'b0100, 1, 4'b0100, 0, 1, 2'd2, 5'd3);
      cyc(4'b0000, 1, 4'b0000, 0, 1, 2'd2, 5'd3);
      cyc(4'b0000, 1, 4'b0000, 0, 1, 2'd2, 5'd3);
      cyc(4'b0000, 1, 4'b0000, 0, 1, 2'd2, 5'd3);
      cyc(4'b0000, 0, 4'b0000, 1, 1, 2'd2, 5'd3);
      cyc(4'b0000, 0, 4'b0000, 0, 1, 2'd2, 5'd4);
      cyc(4'b0000, 0, 4'b0000, 0, 1, 2'd2, 5'd4);
      cyc(4'b0000, 0, 4'b0000, 0, 0, 2'd2, 5'd4);

      // reset mid-burst at burst_cnt 5 (pointer is 3, channel 0 wins)
      cyc(4'b0001, 0, 4'b0001, 0, 0, 2'd2, 5'd4);
      for (int i = 0; i < 5; i++) begin
         cyc(4'b0001, 0, 4'b0001, 1, 1, 2'd0, 5'(i));
      end
      sbq.push_back({4'b0001, 1'b1, 1'b1, 2'd0, 5'd5});
      @(negedge wclk);
      check_pop();
      #1;
      wrst_n = 1'b0;
      #1;
      expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      @(posedge wclk); #1;
      expect_now(4'b0, 1'b0, 1'b0, 2'd0, 5'd0);
      wrst_n = 1'b1;
      cyc(4'b1000, 0, 4'b1000, 0, 0, 2'd0, 5'd0);
      cyc(4'b1000, 0, 4'b1000, 1, 1, 2'd3, 5'd0);
      cyc(4'b0000, 0, 4'b0000, 1, 1, 2'd3, 5'd1);

      // burst cap of 4, sole requester re-granted after rest
      cur = 1;
      cyc(4'b0010, 0, 4'b0010, 0, 0, 2'd0, 5'd0);
      cyc(4'b0010, 0, 4'b0010, 1, 1, 2'd1, 5'd0);
      cyc(4'b0010, 0, 4'b0010, 1, 1, 2'd1, 5'd1);
      cyc(4'b0010, 0, 4'b0010, 1, 1, 2'd1, 5'd2);
      cyc(4'b0010, 0, 4'b0000, 1, 1, 2'd1, 5'd3);
      cyc(4'b0010, 0, 4'b0000, 0, 1, 2'd1, 5'd4);
      cyc(4'b0010, 0, 4'b0000, 0, 1, 2'd1, 5'd4);
      cyc(4'b0010, 0, 4'b0010, 0, 0, 2'd1, 5'd4);
      cyc(4'b0010, 0, 4'b0010, 1, 1, 2'd1, 5'd0);
      cyc(4'b0000, 0, 4'b0000, 1, 1, 2'd1, 5'd1);

      // two channels, no rest gap
      cur = 2;
      cyc(4'b0011, 0, 4'b0001, 0, 0, 2'd0, 5'd0);
      for (int i = 0; i < 16; i++) begin
         cyc(4'b0011, 0, (i != 15) ? 4'b0001 : 4'b0000, 1, 1,
             2'd0, 5'(i));
      end
      cyc(4'b0011, 0, 4'b0010, 0, 0, 2'd0, 5'd16);
      cyc(4'b0011, 0, 4'b0010, 1, 1, 2'd1, 5'd0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule

// File: doc/com_arb_fsm.md
Name: com_arb_fsm

Overview:
- Parametrised successor to the single-requester write-side comms FSM.
- Arbitrates NCH requesters round-robin and grants one channel at a time.
- Produces a write enable for the shared write-domain FIFO, honours FIFO-full backpressure and caps burst length.
- Inserts a configurable rest gap between bursts. Sits between the producer channels and the async FIFO write port, in the wclk domain.

Parameters:
- NCH, 4, number of requesting channels (>=2).
- SELW, 2, width of the channel index (must be >= clog2(NCH)).
- MAX_BURST, 16, maximum writes per granted burst (>=1).
- CNT_W, 5, width of burst_cnt (2^CNT_W > MAX_BURST).
- REST, 2, idle cycles after each burst (0 allowed).

Ports:
- wclk, input, 1, write-domain clock.
- wrst_n, input, 1, reset.
- req, input, NCH, per-channel request, level, held for the whole transfer.
- wfull, input, 1, FIFO full; suppresses writes.
- grant, output, NCH, one-hot grant; at most one bit set.
- w_en, output, 1, FIFO write enable.
- sel, output, SELW, index of the channel owning the bus (registered).
- busy, output, 1, high in DATA or REST.
- burst_cnt, output, CNT_W, writes completed in the current burst.

Behaviour:
- Reset wrst_n, asynchronous, active-low; clock wclk. All flops respond to negedge wrst_n.
- Reset values: state IDLE, rr pointer 0, sel 0, burst_cnt 0, rest counter 0.
- grant and w_en are forced 0 while wrst_n is low. busy is 0 during reset.
- States: IDLE, DATA, REST. The state register is the only source of busy (busy = state != IDLE).
- Arbitration: the winner is the first channel with req high, scanning from the rr pointer upward with wrap (ptr, ptr+1, ..., NCH-1, 0, ..., ptr-1).
- IDLE:
  - If any req is high: grant = onehot(winner) combinationally in the same cycle, w_en 0. On the next edge: sel <= winner, burst_cnt <= 0, state <= DATA.
  - Otherwise grant 0, stay in IDLE.
- DATA:
  - w_en = !wfull.
  - grant[sel] = req[sel] && (burst_cnt != MAX_BURST-1). All other grant bits are 0.
  - burst_cnt increments on every cycle with w_en = 1 and never increments while wfull.
  - Exit when w_en = 1 and (req[sel] = 0 or burst_cnt = MAX_BURST-1). This gives a trailing write in the cycle req drops, as in the single-channel FSM.
  - On exit: rr pointer <= (sel+1) mod NCH. If REST > 0, go to REST with the rest counter <= 0; if REST = 0, go directly to IDLE.
  - While wfull = 1: no write, no count, no exit. The exit is deferred until the first non-full cycle, even if req[sel] has already dropped, so the pending trailing write is never lost.
- REST:
  - grant 0, w_en 0.
  - The rest counter increments each cycle. After exactly REST cycles in REST, go to IDLE.
  - req is ignored in REST.
- MAX_BURST = 1: every burst is exactly one write. grant is 0 throughout DATA (granted only in the IDLE cycle).
- Simultaneous requests: only the arbitration winner is granted. Losers stay pending and are served in later bursts in rotation order.
- A non-selected req changing during DATA has no effect.
- Reset asserted mid-DATA or mid-REST: immediate return to reset values, no further w_en. The partial burst is abandoned.
- Invariants:
  - w_en is 1 only in DATA.
  - popcount(grant) <= 1.
  - burst_cnt never exceeds MAX_BURST.
  - sel is stable for the whole DATA+REST period.

Test Plan:
- Single channel: req[0] high for 3 cycles then low, wfull 0, default params -> grant[0] in IDLE cycle plus 2 DATA cycles; w_en for 3 cycles including the trailing write; burst_cnt 0→3; 2 REST cycles; back to IDLE.
- Contention: req = 4'b1111 held → bursts served in order 0,1,2,3,0. Each burst is capped at 16 writes, then 2 rest cycles. grant stays one-hot throughout.
- Backpressure: channel 2 bursting, wfull high for 4 cycles mid-burst, req[2] drops during wfull → w_en 0 and burst_cnt frozen while full. Exactly one trailing write on the first non-full cycle, then REST.
- Burst cap: MAX_BURST = 4, req[1] held high → w_en for 4 cycles; grant[1] drops with burst_cnt = 3; exit to REST; re-grant to channel 1 only after REST, if it is the sole requester.
- REST = 0, NCH = 2, req = 2'b11 → DATA goes directly to IDLE; the next grant goes to channel 1 in the following cycle.
- Reset mid-burst: assert wrst_n low at burst_cnt = 5 → grant, w_en, busy, burst_cnt and sel all 0 immediately. After release with req[3] high, channel 3 is granted from pointer 0.
